// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures ROM data into the IF/ID register
// and hands it to the decoder over a valid/ready handshake, with early jump redirect.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter bit          EARLY_JUMP = 1'b1
) (
   input  logic        CLK,
   input  logic        RST_n,
   output logic [31:0] PC,
   input  logic [31:0] INST_in,
   input  logic        REDIR,
   input  logic [31:0] REDIR_PC,
   input  logic        ID_Ready,
   output logic        IF_Valid,
   output logic [31:0] IF_PC,
   output logic [31:0] IF_PC4,
   output logic [31:0] IF_INST,
   output logic        IF_IsJump,
   output logic [31:0] FetchCnt
);

   logic [31:0] pc_q, pc_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_pc4_q, if_pc4_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic        if_is_jump_q, if_is_jump_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;

   logic        capture;
   logic        is_jump;
   logic [31:0] pc4;
   logic [31:0] jump_tgt;

   always_comb begin
      capture  = !if_valid_q || ID_Ready;
      pc4      = pc_q + 32'd4;
      is_jump  = EARLY_JUMP && (INST_in[31:26] == 6'b000010);
      jump_tgt = {pc4[31:28], INST_in[25:0], 2'b00};

      pc_d         = pc_q;
      if_valid_d   = if_valid_q;
      if_pc_d      = if_pc_q;
      if_pc4_d     = if_pc4_q;
      if_inst_d    = if_inst_q;
      if_is_jump_d = if_is_jump_q;
      fetch_cnt_d  = fetch_cnt_q;

      // EX redirect wins over capture and over any jump sitting at the current PC.
      if (REDIR) begin
         pc_d       = REDIR_PC & ~32'd3;
         if_valid_d = 1'b0;
      end else if (capture) begin
         if_pc_d      = pc_q;
         if_pc4_d     = pc4;
         if_inst_d    = INST_in;
         if_is_jump_d = is_jump;
         if_valid_d   = 1'b1;
         fetch_cnt_d  = fetch_cnt_q + 32'd1;
         pc_d         = is_jump ? jump_tgt : pc4;
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         pc_q         <= RESET_PC;
         if_valid_q   <= 1'b0;
         if_pc_q      <= '0;
         if_pc4_q     <= '0;
         if_inst_q    <= '0;
         if_is_jump_q <= 1'b0;
         fetch_cnt_q  <= '0;
      end else begin
         pc_q         <= pc_d;
         if_valid_q   <= if_valid_d;
         if_pc_q      <= if_pc_d;
         if_pc4_q     <= if_pc4_d;
         if_inst_q    <= if_inst_d;
         if_is_jump_q <= if_is_jump_d;
         fetch_cnt_q  <= fetch_cnt_d;
      end
   end

   assign PC        = pc_q;
   assign IF_Valid  = if_valid_q;
   assign IF_PC     = if_pc_q;
   assign IF_PC4    = if_pc4_q;
   assign IF_INST   = if_inst_q;
   assign IF_IsJump = if_is_jump_q;
   assign FetchCnt  = fetch_cnt_q;

endmodule
